// File: rtl/fetch_pkg.sv
// Shared fetch types: controller state encoding and default datapath width.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences the PC against a single-outstanding
// imem port, buffers one instruction toward decode and handles redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_stall,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_nxt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_vec,
  output logic              flush_id
);

  fetch_state_t      state, state_nxt;
  logic              drop, drop_nxt;
  logic              req_lat;
  logic [ADDR_W-1:0] req_addr;
  logic              redirect, redir_act, advance, capture;

  assign redirect = trap_req | br_taken;

  always_comb begin
    redir_act = redirect && (state != IDLE);
    advance   = (state == HOLD) && id_ready && !redirect;
    pc_sel    = redir_act;
    flush_id  = redir_act;
    pc_stall  = !(redir_act || advance);
    pc_nxt    = redir_act ? (trap_req ? trap_vec : br_target) : '0;
    if_valid  = (state == HOLD) && !redirect;
    imem_req  = (state == REQ);
    // PC updates on the same edge that enters REQ, so req_addr would capture
    // the stale PC there; the first REQ cycle forwards pc_in, later cycles
    // replay the captured address so it stays stable across a redirect.
    imem_addr = ((state == REQ) && !req_lat) ? pc_in : req_addr;
  end

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    capture   = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (redirect) drop_nxt = 1'b1;
        if (imem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop || redirect) begin
            state_nxt = REQ;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end
        end else if (redirect) begin
          drop_nxt = 1'b1;
        end
      end
      HOLD: if (redirect || id_ready) state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      drop     <= 1'b0;
      req_lat  <= 1'b0;
      req_addr <= '0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state   <= state_nxt;
      drop    <= drop_nxt;
      req_lat <= (state == REQ) && !imem_gnt;
      if (state == REQ) req_addr <= imem_addr;
      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= req_addr;
      end
    end
  end

  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (state == WAIT));

endmodule
